// File: rtl/tky_ctrl_32b.sv
`default_nettype none
// ============================================================================
// Module      : tky_ctrl_32b
// Description : Sequencer for the 32-bit-sliced tweakey register chain.
//               Loads a 128-bit tweakey word by word over a valid/ready pdi
//               handshake, steps it through NR round updates and restores it
//               through the revert path. Chain control {tky_se,tky_enc}:
//               00 hold, 10 shift, 01 round update, 11 restore.
// Revision    : 1.0 - initial release
// ============================================================================
module tky_ctrl_32b #(
    parameter int NR = 40,   // round-update cycles per run (1..63)
    parameter int NW = 4     // 32-bit words per tweakey load
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic       load_start,
    input  logic       run_start,
    input  logic       revert_start,
    input  logic       pdi_valid,
    output logic       pdi_ready,
    output logic       tky_se,
    output logic       tky_enc,
    output logic [5:0] round_cnt,
    output logic       rnd_last,
    output logic       key_valid,
    output logic       updated,
    output logic       busy,
    output logic       done
);

    localparam int             c_WCW    = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [c_WCW-1:0] c_W_LAST = c_WCW'(NW - 1);
    localparam logic [c_WCW-1:0] c_W_ONE  = c_WCW'(1);
    localparam logic [5:0]     c_R_LAST = 6'(NR - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD    = 3'd1;
    localparam logic [2:0] c_READY   = 3'd2;
    localparam logic [2:0] c_RUN     = 3'd3;
    localparam logic [2:0] c_UPDATED = 3'd4;
    localparam logic [2:0] c_REVERT  = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [c_WCW-1:0] r_word_cnt;
    logic [5:0]       r_round_cnt;
    logic             r_key_valid;
    logic             r_updated;

    logic w_accept;
    logic w_load_last;
    logic w_run_last;

    assign w_accept    = (r_state == c_LOAD) && pdi_valid;
    assign w_load_last = w_accept && (r_word_cnt == c_W_LAST);
    assign w_run_last  = (r_state == c_RUN) && (r_round_cnt == c_R_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; commands only sampled in the resting states, load wins
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (load_start) w_next = c_LOAD;
            c_LOAD:    if (w_load_last) w_next = c_READY;
            c_READY:   if (load_start) w_next = c_LOAD;
                       else if (run_start) w_next = c_RUN;
            c_RUN:     if (w_run_last) w_next = c_UPDATED;
            c_UPDATED: if (load_start) w_next = c_LOAD;
                       else if (revert_start) w_next = c_REVERT;
            c_REVERT:  w_next = c_READY;
            default:   w_next = c_IDLE;
        endcase
    end

    // Word and round counters, both wrap to zero on their final step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt  <= '0;
            r_round_cnt <= '0;
        end else begin
            if (w_accept)
                r_word_cnt <= w_load_last ? '0 : r_word_cnt + c_W_ONE;
            if (r_state == c_RUN)
                r_round_cnt <= w_run_last ? 6'd0 : r_round_cnt + 6'd1;
        end
    end

    // Chain-content flags: set/cleared at the completion of each operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_valid <= 1'b0;
            r_updated   <= 1'b0;
        end else if ((r_state != c_LOAD) && (w_next == c_LOAD)) begin
            r_key_valid <= 1'b0;
        end else if (w_load_last || (r_state == c_REVERT)) begin
            r_key_valid <= 1'b1;
            r_updated   <= 1'b0;
        end else if (w_run_last) begin
            r_key_valid <= 1'b0;
            r_updated   <= 1'b1;
        end
    end

    // Output decode from state and the pdi handshake
    always_comb begin
        pdi_ready = 1'b0;
        tky_se    = 1'b0;
        tky_enc   = 1'b0;
        round_cnt = 6'd0;
        rnd_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            c_LOAD: begin
                pdi_ready = 1'b1;
                busy      = 1'b1;
                tky_se    = pdi_valid;
                done      = w_load_last;
            end
            c_RUN: begin
                busy      = 1'b1;
                tky_enc   = 1'b1;
                round_cnt = r_round_cnt;
                rnd_last  = w_run_last;
                done      = w_run_last;
            end
            c_REVERT: begin
                busy      = 1'b1;
                tky_se    = 1'b1;
                tky_enc   = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign key_valid = r_key_valid;
    assign updated   = r_updated;

endmodule
`default_nettype wire

// File: tb/tb_tky_ctrl_32b.sv
`default_nettype none
// ============================================================================
// Module      : tb_tky_ctrl_32b
// Description : Self-checking bench for tky_ctrl_32b. Two instances (NR=40
//               and NR=1) with a behavioural chain model (shift, rotate as
//               round update, inverse rotate as restore).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tky_ctrl_32b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  load_start, run_start, revert_start, pdi_valid;
    logic [31:0] pdi [2];
    logic [1:0]  pdi_ready, tky_se, tky_enc, rnd_last, key_valid, updated, busy, done;
    logic [5:0]  round_cnt [2];

    tky_ctrl_32b #(.NR(40), .NW(4)) u_dut0 (
        .clk(clk), .rst(rst), .load_start(load_start[0]), .run_start(run_start[0]),
        .revert_start(revert_start[0]), .pdi_valid(pdi_valid[0]), .pdi_ready(pdi_ready[0]),
        .tky_se(tky_se[0]), .tky_enc(tky_enc[0]), .round_cnt(round_cnt[0]),
        .rnd_last(rnd_last[0]), .key_valid(key_valid[0]), .updated(updated[0]),
        .busy(busy[0]), .done(done[0])
    );

    tky_ctrl_32b #(.NR(1), .NW(4)) u_dut1 (
        .clk(clk), .rst(rst), .load_start(load_start[1]), .run_start(run_start[1]),
        .revert_start(revert_start[1]), .pdi_valid(pdi_valid[1]), .pdi_ready(pdi_ready[1]),
        .tky_se(tky_se[1]), .tky_enc(tky_enc[1]), .round_cnt(round_cnt[1]),
        .rnd_last(rnd_last[1]), .key_valid(key_valid[1]), .updated(updated[1]),
        .busy(busy[1]), .done(done[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference knowledge of what each chain should hold
    bit           key_ok [2];
    bit           upd    [2];
    logic [127:0] golden [2];
    logic [127:0] chain  [2];

    function automatic int nr_of(int i);
        return (i == 0) ? 40 : 1;
    endfunction

    function automatic logic [127:0] rotl(logic [127:0] x, int n);
        int m;
        m = n % 128;
        return (x << m) | (x >> (128 - m));
    endfunction

    // Datapath model reacting to the controller's chain controls
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            case ({tky_se[i], tky_enc[i]})
                2'b10: chain[i] <= {chain[i][95:0], pdi[i]};
                2'b01: chain[i] <= rotl(chain[i], 5);
                2'b11: chain[i] <= rotl(chain[i], 128 - (5 * nr_of(i)) % 128);
                default: ;
            endcase
        end
    end

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // {pdi_ready,se,enc,round_cnt,rnd_last,key_valid,updated,busy,done}
    function automatic logic [13:0] outs(int i);
        return {pdi_ready[i], tky_se[i], tky_enc[i], round_cnt[i], rnd_last[i],
                key_valid[i], updated[i], busy[i], done[i]};
    endfunction

    function automatic logic [13:0] exp_o(bit rdy, bit se, bit enc, int rc, bit last,
                                          bit kv, bit up, bit bsy, bit dn);
        return {rdy, se, enc, 6'(rc), last, kv, up, bsy, dn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(int i, bit fixed, bit also_run);
        logic [31:0] w [4];
        logic [5:0]  pat;
        int acc, cyc;
        bit v;
        pat = 6'b101101;  // valid pattern 1,0,1,1,0,1 in cycle order
        acc = 0;
        cyc = 0;
        load_start[i] = 1'b1;
        run_start[i]  = also_run;
        #1;
        check("load_cmd", outs(i), exp_o(0, 0, 0, 0, 0, key_ok[i], upd[i], 0, 0));
        tick();
        load_start[i] = 1'b0;
        run_start[i]  = 1'b0;
        key_ok[i] = 1'b0;
        while (acc < 4 && cyc < 64) begin
            v = fixed ? pat[cyc % 6] : 1'($urandom_range(0, 1));
            pdi_valid[i] = v;
            pdi[i] = $urandom;
            #1;
            check("load_cyc", outs(i), exp_o(1, v, 0, 0, 0, 0, upd[i], 1, v && (acc == 3)));
            if (v) begin
                w[acc] = pdi[i];
                acc++;
            end
            tick();
            cyc++;
        end
        pdi_valid[i] = 1'b0;
        if (acc < 4) check("load_timeout", acc, 4);
        key_ok[i] = 1'b1;
        upd[i]    = 1'b0;
        golden[i] = {w[0], w[1], w[2], w[3]};
        #1;
        check("load_end", outs(i), exp_o(0, 0, 0, 0, 0, 1, 0, 0, 0));
        check("load_chain", chain[i], golden[i]);
        if (fixed) check("load_len", cyc, 6);
    endtask

    task automatic do_run(int i, bit poke);
        int n;
        n = nr_of(i);
        run_start[i] = 1'b1;
        #1;
        check("run_cmd", outs(i), exp_o(0, 0, 0, 0, 0, key_ok[i], upd[i], 0, 0));
        tick();
        run_start[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            load_start[i]   = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            revert_start[i] = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check("run_cyc", outs(i), exp_o(0, 0, 1, k, k == n - 1, 1, 0, 1, k == n - 1));
            tick();
        end
        load_start[i]   = 1'b0;
        revert_start[i] = 1'b0;
        key_ok[i] = 1'b0;
        upd[i]    = 1'b1;
        #1;
        check("run_end", outs(i), exp_o(0, 0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    task automatic do_revert(int i);
        revert_start[i] = 1'b1;
        #1;
        check("rev_cmd", outs(i), exp_o(0, 0, 0, 0, 0, key_ok[i], upd[i], 0, 0));
        tick();
        revert_start[i] = 1'b0;
        #1;
        check("rev_cyc", outs(i), exp_o(0, 1, 1, 0, 0, 0, 1, 1, 1));
        tick();
        key_ok[i] = 1'b1;
        upd[i]    = 1'b0;
        #1;
        check("rev_end", outs(i), exp_o(0, 0, 0, 0, 0, 1, 0, 0, 0));
        check("rev_chain", chain[i], golden[i]);
    endtask

    // Commands that must have no effect in the current resting state
    task automatic do_ignore(int i, bit with_revert);
        run_start[i]    = 1'b1;
        revert_start[i] = with_revert;
        #1;
        check("ign_cmd", outs(i), exp_o(0, 0, 0, 0, 0, key_ok[i], upd[i], 0, 0));
        tick();
        run_start[i]    = 1'b0;
        revert_start[i] = 1'b0;
        #1;
        check("ign_after", outs(i), exp_o(0, 0, 0, 0, 0, key_ok[i], upd[i], 0, 0));
        tick();
    endtask

    initial begin
        rst = 1'b0;
        load_start = '0; run_start = '0; revert_start = '0; pdi_valid = '0;
        pdi[0] = '0; pdi[1] = '0;
        for (int i = 0; i < 2; i++) begin
            key_ok[i] = 0; upd[i] = 0; golden[i] = '0;
        end
        #2;
        check("reset0", outs(0), '0);
        check("reset1", outs(1), '0);
        @(posedge clk); #3;
        rst = 1'b1;
        tick();

        // Asynchronous reset in the middle of a run, at round 17
        do_load(0, 0, 0);
        run_start[0] = 1'b1;
        tick();
        run_start[0] = 1'b0;
        repeat (17) tick();
        #1;
        check("run_r17", outs(0), exp_o(0, 0, 1, 17, 0, 1, 0, 1, 0));
        #2;
        rst = 1'b0;
        #1;
        check("areset0", outs(0), '0);
        check("areset1", outs(1), '0);
        @(negedge clk);
        rst = 1'b1;
        key_ok[0] = 0; upd[0] = 0;
        tick();
        do_ignore(0, 1);

        // Directed sequence on the NR=40 instance
        do_load(0, 1, 0);
        do_run(0, 1);
        do_ignore(0, 0);
        do_revert(0);
        do_load(0, 0, 1);

        // Random legal command sequence
        repeat (6) begin
            if (upd[0]) begin
                if ($urandom_range(0, 3) != 0) do_revert(0);
                else do_load(0, 0, 0);
            end else begin
                if ($urandom_range(0, 3) != 0) do_run(0, 1);
                else do_load(0, 0, 0);
            end
        end

        // NR=1 instance: single-cycle runs
        repeat (3) begin
            do_load(1, 0, 0);
            do_run(1, 0);
            do_revert(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
